fifo_cascade_axi_to_classic: RTL and testbench
==============================================

// Module: fifo_cascade_axi_to_classic
// PURPOSE
//  Return-path buffer: accepts AXI-Stream words from the processing core and presents them on the
//  classic src_rdy/dst_rdy handshake toward the external data sink. Structure: 2-entry AXI input
//  skid stage, a 2^SIZE block-RAM circular buffer, and a 2-stage registered output.
//  Reports combined space/occupied so host software can size bursts.
// PARAMETERS
//  WIDTH  32  data word width in bits
//  SIZE   9   log2 of block-RAM depth; legal 4..12 (total capacity 2^SIZE+4 must fit 16 bits)
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  clear      in   1      synchronous flush, active high
//  i_tdata    in   WIDTH  AXI input data
//  i_tvalid   in   1      AXI input valid
//  i_tready   out  1      block can accept a word (registered)
//  dataout    out  WIDTH  classic output data (registered)
//  src_rdy_o  out  1      dataout holds a valid word
//  dst_rdy_i  in   1      external sink accepts dataout
//  space      out  16     free entries across all stages
//  occupied   out  16     held entries across all stages
// BEHAVIOUR
//  Reset (reset_n=0, async): all counts and pointers 0; i_tready=0, src_rdy_o=0, dataout=0,
//   occupied=0, space=2^SIZE+4. i_tready rises on the first clk edge after reset_n deasserts.
//  Input handshake: word taken on an edge where i_tvalid & i_tready.
//   i_tready = registered (skid_cnt<2); never combinationally dependent on dst_rdy_i.
//  Skid -> RAM: head skid word is written at wr_ptr when ram_cnt < 2^SIZE.
//   At most one RAM write per cycle; no write when ram_cnt = 2^SIZE.
//  RAM read: synchronous, 1-cycle read. Read issued when ram_cnt>0 and (!rd_valid | rd_move).
//   rd_move = rd_valid & (!src_rdy_o | (src_rdy_o & dst_rdy_i)). The RAM output holds while
//   rd_valid & !rd_move.
//  Output handshake: a transfer completes on an edge with src_rdy_o & dst_rdy_i.
//   dataout/src_rdy_o load from the RAM stage on rd_move. Otherwise they drop after a transfer
//   and hold when not accepted; dataout is stable while src_rdy_o=1 & dst_rdy_i=0.
//  Pointers: wr_ptr/rd_ptr are SIZE bits and wrap 2^SIZE-1 -> 0. ram_cnt is SIZE+1 bits:
//   +1 on write, -1 on read, unchanged on simultaneous write and read.
//  Latency, empty block: word accepted on edge N -> src_rdy_o=1 after edge N+3.
//  Throughput: 1 word/clk sustained with i_tvalid=1 and dst_rdy_i=1.
//  occupied = skid_cnt + ram_cnt + rd_valid + src_rdy_o, zero-extended to 16 bits.
//   space = (2^SIZE+4) - occupied. Both are updated from registered state, so they reflect the
//   current cycle.
//  Full: occupied = 2^SIZE+4, i_tready=0. The first dst_rdy_i transfer reopens i_tready within
//   4 clocks, as data drains stage by stage.
//  clear (sync): overrides handshakes on the same edge; in-flight and stored words are discarded.
//   Next cycle: pointers/counts 0, src_rdy_o=0, i_tready=1, occupied=0. Any word offered on the
//   clear edge is dropped.
//  reset_n asserted mid-transfer: immediate return to reset state; no partial word is emitted.
// STRUCTURE
//  Shared header fifo_defs.vh: localparams SKID_DEPTH=2, OUT_STAGES=2,
//   and CAPACITY(SIZE)=2^SIZE+SKID_DEPTH+OUT_STAGES.
//  Sub-module axi_skid_buffer (2-entry, registered tready, WIDTH param), instantiated on the input.
//  The RAM is an inferred simple-dual-port array in this module. The output pipeline and counters
//   are inline.
// TESTING
//  1 Single word: reset, i_tdata=32'hA5A5_0001 one cycle -> src_rdy_o=1 after 3 edges,
//    dataout=32'hA5A5_0001; occupied 1 -> 0 after dst_rdy_i transfer.
//  2 Streaming: 1000 incrementing words, i_tvalid=1, dst_rdy_i=1 -> in-order output,
//    1 word/clk after fill, no gaps, no loss.
//  3 Fill (SIZE=4): dst_rdy_i=0, push 25 words -> exactly 20 accepted, i_tready=0,
//    occupied=20, space=0. Then dst_rdy_i=1 -> words 0..19 in order.
//  4 Backpressure: random i_tvalid/dst_rdy_i (50%) over 2^SIZE*3 words -> scoreboard match.
//    dataout stable whenever src_rdy_o & !dst_rdy_i.
//  5 Wrap: SIZE=4, 40 words with dst_rdy_i toggled every 3 clks -> correct order across
//    pointer wrap 15 -> 0.
//  6 Clear/reset: clear with 7 words held -> next cycle occupied=0, src_rdy_o=0, i_tready=1,
//    old data never emitted. Repeat with reset_n pulse mid-burst -> same result,
//    i_tready=0 until first edge after release.

Source files
------------

// File: rtl/fifo_cascade_axi_to_classic_pkg.sv
// Shared sizing constants for the AXI-to-classic return-path buffer.
// Total capacity is the block-RAM depth plus the skid and output pipeline stages.
package fifo_cascade_axi_to_classic_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OUT_STAGES = 2;

  function automatic int unsigned capacity(input int unsigned size);
    return (32'd1 << size) + SKID_DEPTH + OUT_STAGES;
  endfunction

endpackage

// File: rtl/fifo_cascade_axi_to_classic_axi_skid_buffer.sv
// Two-entry AXI-Stream skid stage with a registered tready.
// The entry at the head is always presented on the output side.
module axi_skid_buffer
  import fifo_cascade_axi_to_classic_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  always_comb begin
    push   = i_tvalid & rdy_q;
    pop    = o_tready & (cnt_q != 2'd0);
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = i_tdata;
          else               tail_d = i_tdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = i_tdata;
          end else begin
            head_d = tail_q;
            tail_d = i_tdata;
          end
        end
        default: ;
      endcase
    end
    // tready is a flop of the next count, so it never sees downstream readiness combinationally
    rdy_d = (cnt_d < 2'(SKID_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign i_tready = rdy_q;
  assign o_tdata  = head_q;
  assign o_tvalid = (cnt_q != 2'd0);
  assign count    = cnt_q;

endmodule

// File: rtl/fifo_cascade_axi_to_classic.sv
// Return-path buffer: AXI-Stream in, skid stage, block-RAM ring, two registered
// output stages, classic src_rdy/dst_rdy out, with combined space/occupied reporting.
module fifo_cascade_axi_to_classic
  import fifo_cascade_axi_to_classic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [15:0]      space,
  output logic [15:0]      occupied
);

  localparam int unsigned DEPTH = 1 << SIZE;
  localparam int unsigned CAP   = capacity(SIZE);
  localparam logic [SIZE:0] RAM_FULL = (SIZE+1)'(DEPTH);

  logic [WIDTH-1:0] skid_tdata;
  logic             skid_tvalid, skid_tready;
  logic [1:0]       skid_cnt;

  axi_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (skid_tdata),
    .o_tvalid (skid_tvalid),
    .o_tready (skid_tready),
    .count    (skid_cnt)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [SIZE-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SIZE:0]    ram_cnt_q, ram_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic             src_rdy_q, src_rdy_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             wr_en, rd_en, rd_move;

  assign skid_tready = (ram_cnt_q != RAM_FULL);

  always_comb begin
    wr_en      = skid_tvalid & skid_tready & ~clear;
    rd_move    = rd_valid_q & (~src_rdy_q | dst_rdy_i);
    rd_en      = (ram_cnt_q != '0) & (~rd_valid_q | rd_move) & ~clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_valid_d = rd_valid_q;
    src_rdy_d  = src_rdy_q;
    dataout_d  = dataout_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      rd_valid_d = 1'b0;
      src_rdy_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + SIZE'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + SIZE'(1);
      unique case ({wr_en, rd_en})
        2'b10:   ram_cnt_d = ram_cnt_q + (SIZE+1)'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - (SIZE+1)'(1);
        default: ;
      endcase
      if (rd_en)        rd_valid_d = 1'b1;
      else if (rd_move) rd_valid_d = 1'b0;
      if (rd_move) begin
        src_rdy_d = 1'b1;
        dataout_d = rd_data_q;
      end else if (src_rdy_q & dst_rdy_i) begin
        src_rdy_d = 1'b0;
      end
    end
  end

  // Memory and its read register stay reset-free so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= skid_tdata;
    if (rd_en) rd_data_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      src_rdy_q  <= 1'b0;
      dataout_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_valid_q <= rd_valid_d;
      src_rdy_q  <= src_rdy_d;
      dataout_q  <= dataout_d;
    end
  end

  assign dataout   = dataout_q;
  assign src_rdy_o = src_rdy_q;
  assign occupied  = 16'(skid_cnt) + 16'(ram_cnt_q) + 16'(rd_valid_q) + 16'(src_rdy_q);
  assign space     = 16'(CAP) - occupied;

endmodule

// File: tb/tb_fifo_cascade_axi_to_classic.sv
// Directed bench for fifo_cascade_axi_to_classic at SIZE=4 (capacity 20),
// with a queue scoreboard of accepted words checked at every output transfer.
module tb_fifo_cascade_axi_to_classic;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i = 1'b0;
  logic [15:0] space, occupied;

  fifo_cascade_axi_to_classic #(.WIDTH(32), .SIZE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .i_tdata   (i_tdata),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .dataout   (dataout),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .space     (space),
    .occupied  (occupied)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c,
                      output logic acc, output logic xf);
    i_tvalid  = v;
    i_tdata   = d;
    dst_rdy_i = r;
    clear     = c;
    #1;
    acc = v & i_tready & ~c;
    xf  = src_rdy_o & r & ~c;
    if (hold_v) check("hold_stable", dataout, hold_d);
    if (acc) exp_q.push_back(d);
    if (xf) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_data", dataout, exp_q.pop_front());
    end
    hold_v = src_rdy_o & ~r & ~c;
    hold_d = dataout;
    @(posedge clk);
    @(negedge clk);
    if (c) begin
      exp_q.delete();
      hold_v = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain(input int unsigned bound);
    logic a, x;
    for (int unsigned k = 0; k < bound && exp_q.size() != 0; k++) step(1'b0, '0, 1'b1, 1'b0, a, x);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_occ", 32'(occupied), 32'd0);
  endtask

  initial begin
    logic a, x;
    int   n_acc, n_xf, first_x, last_x, k;

    // reset state
    #12;
    check("rst_tready", 32'(i_tready), 32'd0);
    check("rst_srcrdy", 32'(src_rdy_o), 32'd0);
    check("rst_dataout", dataout, 32'd0);
    check("rst_occ", 32'(occupied), 32'd0);
    check("rst_space", 32'(space), 32'd20);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_tready_low", 32'(i_tready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_tready_high", 32'(i_tready), 32'd1);

    // single word, 3-edge latency
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, a, x);
    check("t1_acc", 32'(a), 32'd1);
    check("t1_occ1", 32'(occupied), 32'd1);
    check("t1_n1", 32'(src_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, a, x);
    check("t1_n2", 32'(src_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, a, x);
    check("t1_n3", 32'(src_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, a, x);
    check("t1_srcrdy", 32'(src_rdy_o), 32'd1);
    check("t1_data", dataout, 32'hA5A5_0001);
    check("t1_occ_held", 32'(occupied), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, a, x);
    check("t1_xfer", 32'(x), 32'd1);
    check("t1_occ0", 32'(occupied), 32'd0);
    check("t1_space", 32'(space), 32'd20);
    check("t1_srcrdy0", 32'(src_rdy_o), 32'd0);

    // streaming: 1000 words, no gaps
    n_acc = 0; n_xf = 0; first_x = -1; last_x = -1;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0, a, x);
      n_acc += int'(a);
      if (x) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_xf++;
      end
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, a, x);
      if (x) begin
        last_x = cyc;
        n_xf++;
      end
    end
    check("t2_accepted", 32'(n_acc), 32'd1000);
    check("t2_delivered", 32'(n_xf), 32'd1000);
    check("t2_no_gaps", 32'(last_x - first_x), 32'd999);
    drain(10);

    // fill to capacity
    n_acc = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 32'(100 + i), 1'b0, 1'b0, a, x);
      n_acc += int'(a);
    end
    check("t3_accepted", 32'(n_acc), 32'd20);
    check("t3_tready", 32'(i_tready), 32'd0);
    check("t3_occ", 32'(occupied), 32'd20);
    check("t3_space", 32'(space), 32'd0);
    check("t3_head", dataout, 32'd100);
    step(1'b0, '0, 1'b1, 1'b0, a, x);
    k = 0;
    while (!i_tready && k < 8) begin
      step(1'b0, '0, 1'b1, 1'b0, a, x);
      k++;
    end
    check("t3_reopen", 32'(k <= 3), 32'd1);
    drain(40);

    // random backpressure, 48 words
    n_acc = 0;
    for (int i = 0; i < 2000 && n_acc < 48; i++) begin
      step(1'($urandom_range(0, 1)), 32'(1000 + n_acc), 1'($urandom_range(0, 1)), 1'b0, a, x);
      n_acc += int'(a);
    end
    check("t4_accepted", 32'(n_acc), 32'd48);
    drain(60);

    // pointer wrap: 40 words, sink toggles every 3 clocks
    n_acc = 0;
    for (int i = 0; i < 400 && n_acc < 40; i++) begin
      step(1'b1, 32'(2000 + n_acc), 1'((cyc / 3) % 2), 1'b0, a, x);
      n_acc += int'(a);
    end
    check("t5_accepted", 32'(n_acc), 32'd40);
    drain(60);

    // clear with 7 words held
    for (int i = 0; i < 7; i++) step(1'b1, 32'(3000 + i), 1'b0, 1'b0, a, x);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, a, x);
    check("t6_occ7", 32'(occupied), 32'd7);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, a, x);
    check("t6_clr_occ", 32'(occupied), 32'd0);
    check("t6_clr_srcrdy", 32'(src_rdy_o), 32'd0);
    check("t6_clr_tready", 32'(i_tready), 32'd1);
    step(1'b1, 32'h0000_0077, 1'b1, 1'b0, a, x);
    drain(10);

    // async reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, 32'(4000 + i), 1'b1, 1'b0, a, x);
    i_tvalid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    hold_v = 1'b0;
    check("t6_rst_srcrdy", 32'(src_rdy_o), 32'd0);
    check("t6_rst_occ", 32'(occupied), 32'd0);
    check("t6_rst_tready", 32'(i_tready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_rel_tready0", 32'(i_tready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t6_rel_tready1", 32'(i_tready), 32'd1);
    check("t6_rel_srcrdy", 32'(src_rdy_o), 32'd0);
    step(1'b1, 32'h0000_0088, 1'b1, 1'b0, a, x);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
